// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter (EXU/LSU round-robin) with registered register-stack write port and busy scoreboard.
// Optional define WB_BYPASS_EN forwards the in-flight output-stage write to the decode source ports.
module reg_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              exu_valid,
    input  logic [ADDR_W-1:0] exu_rd,
    input  logic [DATA_W-1:0] exu_data,
    output logic              exu_ready,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_rd_value,
    output logic              rf_wen,
    output logic [DATA_W-1:0] rs1_fwd_data,
    output logic [DATA_W-1:0] rs2_fwd_data
);
    localparam int NREG = 1 << ADDR_W;

    typedef enum logic {
        GRANT_EXU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

    grant_e            last_grant;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_next;
    logic              grant_exu;
    logic              grant_lsu;
    logic              grant_any;
    logic              issue_fire;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

    // Handshake: a transfer happens in a cycle where valid & ready are both 1; ready never
    // depends on anything but the valids and last_grant, and a requester holds rd/data while
    // valid & ~ready.
    always_comb begin
        grant_exu = exu_valid & (~lsu_valid | (last_grant == GRANT_LSU));
        grant_lsu = lsu_valid & ~grant_exu;
        grant_any = grant_exu | grant_lsu;
        wb_rd     = grant_lsu ? lsu_rd   : exu_rd;
        wb_data   = grant_lsu ? lsu_data : exu_data;
    end

    assign exu_ready = grant_exu;
    assign lsu_ready = grant_lsu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GRANT_LSU;
        end else if (grant_exu) begin
            last_grant <= GRANT_EXU;
        end else if (grant_lsu) begin
            last_grant <= GRANT_LSU;
        end
    end

    // rd==0 writes are consumed but never reach the stack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen      <= 1'b0;
            rf_rd       <= '0;
            rf_rd_value <= '0;
        end else begin
            rf_wen <= grant_any & (wb_rd != '0);
            if (grant_any) begin
                rf_rd       <= wb_rd;
                rf_rd_value <= wb_data;
            end
        end
    end

    assign issue_ready = ~busy[issue_rd] | (issue_rd == '0);
    assign issue_fire  = issue_valid & issue_ready & (issue_rd != '0);

    // Priority low to high: writeback clear, issue set, flush.
    always_comb begin
        busy_next = busy;
        if (rf_wen) begin
            busy_next[rf_rd] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

`ifdef WB_BYPASS_EN
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit      = rf_wen & (rf_rd == rs1_addr) & (rf_rd != '0);
    assign rs2_hit      = rf_wen & (rf_rd == rs2_addr) & (rf_rd != '0);
    assign rs1_busy     = busy[rs1_addr] & ~rs1_hit;
    assign rs2_busy     = busy[rs2_addr] & ~rs2_hit;
    assign rs1_fwd_data = rs1_hit ? rf_rd_value : '0;
    assign rs2_fwd_data = rs2_hit ? rf_rd_value : '0;
`else
    assign rs1_busy     = busy[rs1_addr];
    assign rs2_busy     = busy[rs2_addr];
    assign rs1_fwd_data = '0;
    assign rs2_fwd_data = '0;
`endif

endmodule
